// File: rtl/mult_div_unit.sv
//------------------------------------------------------------------------------
// mult_div_unit: iterative 32-bit MULT/MULTU/DIV/DIVU unit (shift-add / restoring)
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mult_div_unit (
  input  logic        CLK,
  input  logic        RST,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] port_a,
  input  logic [31:0] port_b,
  input  logic        cancel,
  output logic        busy,
  output logic        done,
  output logic        dz,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [4:0]  r_cnt;
  logic [1:0]  r_op;
  logic        r_sign_a;
  logic        r_sign_b;
  logic        r_dz;
  word_t       r_a_raw;
  word_t       r_mag_a;
  word_t       r_mag_b;
  logic [63:0] r_acc;
  word_t       r_rem;
  word_t       r_quo;
  word_t       r_hi;
  word_t       r_lo;
  logic        r_dz_out;
  logic        r_done;

  logic        w_signed;
  logic        w_sa;
  logic        w_sb;
  word_t       w_mag_a;
  word_t       w_mag_b;
  logic [32:0] w_sum;
  logic [32:0] w_shift;
  logic        w_ge;
  word_t       w_diff;
  logic [63:0] w_prod;
  word_t       w_fix_hi;
  word_t       w_fix_lo;

  // Signed ops work on two's-complement magnitudes; 0x80000000 stays 0x80000000.
  assign w_signed = ~op[0];
  assign w_sa     = w_signed & port_a[31];
  assign w_sb     = w_signed & port_b[31];
  assign w_mag_a  = w_sa ? (~port_a + 32'd1) : port_a;
  assign w_mag_b  = w_sb ? (~port_b + 32'd1) : port_b;

  assign w_sum    = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_mag_a} : 33'd0);

  assign w_shift  = {r_rem, r_quo[31]};
  assign w_ge     = (w_shift >= {1'b0, r_mag_b});
  assign w_diff   = w_shift[31:0] - r_mag_b;

  always_comb begin
    w_prod   = r_acc;
    w_fix_hi = r_acc[63:32];
    w_fix_lo = r_acc[31:0];
    if (r_dz) begin
      w_fix_hi = r_a_raw;
      w_fix_lo = 32'hFFFF_FFFF;
    end else if (r_op[1]) begin
      w_fix_hi = r_sign_a ? (~r_rem + 32'd1) : r_rem;
      w_fix_lo = (r_sign_a ^ r_sign_b) ? (~r_quo + 32'd1) : r_quo;
    end else begin
      // Sign flags are zero for MULTU, so no op check is needed here.
      if (r_sign_a ^ r_sign_b) w_prod = ~r_acc + 64'd1;
      w_fix_hi = w_prod[63:32];
      w_fix_lo = w_prod[31:0];
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: if (start) w_state_nxt = CALC;
      CALC: begin
        if (cancel)            w_state_nxt = IDLE;
        else if (r_cnt == 5'd0) w_state_nxt = FIX;
      end
      FIX:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_cnt    <= 5'd0;
      r_op     <= 2'd0;
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      r_dz     <= 1'b0;
      r_a_raw  <= '0;
      r_mag_a  <= '0;
      r_mag_b  <= '0;
      r_acc    <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_dz_out <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_op     <= op;
            r_sign_a <= w_sa;
            r_sign_b <= w_sb;
            r_dz     <= op[1] & (port_b == 32'd0);
            r_a_raw  <= port_a;
            r_mag_a  <= w_mag_a;
            r_mag_b  <= w_mag_b;
            r_acc    <= {32'd0, w_mag_b};
            r_rem    <= '0;
            r_quo    <= w_mag_a;
            r_cnt    <= 5'd31;
          end
        end
        CALC: begin
          // Both datapaths step every cycle; only the one matching r_op is used at FIX.
          r_cnt <= r_cnt - 5'd1;
          r_acc <= {w_sum, r_acc[31:1]};
          r_rem <= w_ge ? w_diff : w_shift[31:0];
          r_quo <= {r_quo[30:0], w_ge};
        end
        FIX: begin
          if (!cancel) begin
            r_hi     <= w_fix_hi;
            r_lo     <= w_fix_lo;
            r_dz_out <= r_dz;
            r_done   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (r_state != IDLE);
  assign done = r_done;
  assign dz   = r_dz_out;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_mult_div_unit.sv
//------------------------------------------------------------------------------
// tb_mult_div_unit: table-driven check of mult_div_unit plus handshake corner cases
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_mult_div_unit;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] port_a = '0;
  logic [31:0] port_b = '0;
  logic        cancel = 1'b0;
  logic        busy, done, dz;
  logic [31:0] hi, lo;

  int n_tests = 0;
  int n_fail  = 0;

  mult_div_unit dut (
    .CLK(CLK), .RST(RST), .start(start), .op(op), .port_a(port_a),
    .port_b(port_b), .cancel(cancel), .busy(busy), .done(done),
    .dz(dz), .hi(hi), .lo(lo)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Issues one op and waits (bounded) for done; lat is edges from the start edge.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic busy0);
    @(negedge CLK);
    start = 1'b1; op = o; port_a = a; port_b = b;
    @(posedge CLK); #1;
    start = 1'b0;
    busy0 = busy;
    lat = 0;
    while (done !== 1'b1 && lat < 40) begin
      @(posedge CLK); #1;
      lat++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    logic        b0;
    int          ndone;
    int          first;
    logic [31:0] cap_hi, cap_lo;

    vecs[0]  = '{2'b00, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
    vecs[1]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vecs[2]  = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0};
    vecs[3]  = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[4]  = '{2'b11, 32'hFFFFFFF9, 32'h00000002, 32'h00000001, 32'h7FFFFFFC, 1'b0};
    vecs[5]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vecs[6]  = '{2'b11, 32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF, 1'b1};
    vecs[7]  = '{2'b01, 32'h00000002, 32'h00000003, 32'h00000000, 32'h00000006, 1'b0};
    vecs[8]  = '{2'b10, 32'hFFFFFF9C, 32'h00000000, 32'hFFFFFF9C, 32'hFFFFFFFF, 1'b1};
    vecs[9]  = '{2'b10, 32'h00000064, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFF2, 1'b0};
    vecs[10] = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};

    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_done", {63'd0, done}, 64'd0);
    chk("reset_dz",   {63'd0, dz},   64'd0);
    chk("reset_hi",   {32'd0, hi},   64'd0);
    chk("reset_lo",   {32'd0, lo},   64'd0);

    for (int i = 0; i < 11; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, b0);
      chk($sformatf("v%0d_latency", i), 64'(lat), 64'd33);
      chk($sformatf("v%0d_busy_after_start", i), {63'd0, b0}, 64'd1);
      chk($sformatf("v%0d_busy_at_done", i), {63'd0, busy}, 64'd0);
      chk($sformatf("v%0d_hi", i), {32'd0, hi}, {32'd0, vecs[i].hi});
      chk($sformatf("v%0d_lo", i), {32'd0, lo}, {32'd0, vecs[i].lo});
      chk($sformatf("v%0d_dz", i), {63'd0, dz}, {63'd0, vecs[i].dz});
    end

    // start while busy is ignored
    @(negedge CLK);
    start = 1'b1; op = 2'b01; port_a = 32'd5; port_b = 32'd5;
    @(posedge CLK); #1;
    start = 1'b0;
    ndone = 0; first = 0; cap_hi = '0; cap_lo = '0;
    for (int i = 1; i <= 45; i++) begin
      if (i == 10) begin
        start = 1'b1; op = 2'b11; port_a = 32'd9; port_b = 32'd3;
      end
      @(posedge CLK); #1;
      if (i == 10) start = 1'b0;
      if (done === 1'b1) begin
        ndone++;
        if (first == 0) begin
          first = i; cap_hi = hi; cap_lo = lo;
        end
      end
    end
    chk("ignore_done_count", 64'(ndone), 64'd1);
    chk("ignore_latency", 64'(first), 64'd33);
    chk("ignore_hi", {32'd0, cap_hi}, 64'd0);
    chk("ignore_lo", {32'd0, cap_lo}, 64'd25);

    // cancel mid-CALC
    @(negedge CLK);
    start = 1'b1; op = 2'b11; port_a = 32'd9; port_b = 32'd3;
    @(posedge CLK); #1;
    start = 1'b0;
    repeat (19) begin
      @(posedge CLK); #1;
    end
    cancel = 1'b1;
    @(posedge CLK); #1;
    cancel = 1'b0;
    chk("cancel_busy", {63'd0, busy}, 64'd0);
    ndone = 0;
    repeat (40) begin
      @(posedge CLK); #1;
      if (done === 1'b1) ndone++;
    end
    chk("cancel_no_done", 64'(ndone), 64'd0);
    chk("cancel_hi", {32'd0, hi}, 64'd0);
    chk("cancel_lo", {32'd0, lo}, 64'd25);

    // asynchronous reset mid-CALC
    @(negedge CLK);
    start = 1'b1; op = 2'b00; port_a = 32'd5; port_b = 32'd7;
    @(posedge CLK); #1;
    start = 1'b0;
    repeat (10) @(posedge CLK);
    #3;
    RST = 1'b1;
    #1;
    chk("arst_busy", {63'd0, busy}, 64'd0);
    chk("arst_hi",   {32'd0, hi},   64'd0);
    chk("arst_lo",   {32'd0, lo},   64'd0);
    chk("arst_dz",   {63'd0, dz},   64'd0);
    @(negedge CLK);
    RST = 1'b0;
    ndone = 0;
    repeat (40) begin
      @(posedge CLK); #1;
      if (done === 1'b1) ndone++;
    end
    chk("arst_no_done", 64'(ndone), 64'd0);

    run_op(2'b00, 32'd2, 32'hFFFFFFFF, lat, b0);
    chk("post_rst_latency", 64'(lat), 64'd33);
    chk("post_rst_hi", {32'd0, hi}, 64'hFFFFFFFF);
    chk("post_rst_lo", {32'd0, lo}, 64'hFFFFFFFE);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
